// File: rtl/matmul_pkg.sv
// Shared constants and FSM state encoding for the 4x4 Q8.8 matrix-multiply block.
// No logic; imported by the sequencer, its index counter and the bench.
package matmul_pkg;

    localparam int DIM   = 4;
    localparam int N     = 16;
    localparam int Q     = 8;
    localparam int ELEMS = DIM * DIM;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LOAD   = 3'd1;
    localparam state_t S_DRAIN  = 3'd2;
    localparam state_t S_SETTLE = 3'd3;
    localparam state_t S_STORE  = 3'd4;
    localparam state_t S_DONE   = 3'd5;

endpackage

// File: rtl/matmul_idx_cnt.sv
// Element index up-counter with clear/enable and a terminal-count flag.
// Latency: count visible the cycle after enable; tc is combinational on the current count.
// Backpressure: none; the owner holds en low to stall.
module matmul_idx_cnt #(
    parameter int ADDR_W = 4,
    parameter int TERM   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + ADDR_W'(1);
    end

    assign tc = en && (cnt == ADDR_W'(TERM));

endmodule

// File: rtl/matmul_sequencer.sv
// Start/busy/done job sequencer for the 4x4 matmul datapath: ROM load, settle, RAM store.
// Latency: done pulses 33+RD_LAT+CALC_LAT cycles after start is accepted.
// Backpressure: none; start is ignored while busy, abort cancels the job at the next edge.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DIM      = matmul_pkg::DIM,
    parameter int ADDR_W   = 4,
    parameter int RD_LAT   = 1,
    parameter int CALC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_raddr,
    output logic              cap_en,
    output logic [ADDR_W-1:0] cap_idx,
    output logic [ADDR_W-1:0] res_idx,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_waddr,
    input  logic              ovf_in,
    output logic              ovf_sticky
);

    localparam int TERM     = DIM * DIM - 1;
    localparam int WAIT_MAX = (RD_LAT > CALC_LAT) ? RD_LAT : CALC_LAT;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              idx_en;
    logic              idx_clr;
    logic              idx_tc;
    logic [ADDR_W-1:0] idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_end;
    logic [RD_LAT-1:0] pipe_vld;
    logic [ADDR_W-1:0] pipe_idx [RD_LAT];

    assign accept   = (state == S_IDLE) && start && !abort;
    assign idx_en   = (state == S_LOAD) || (state == S_STORE);
    // Clear on the terminal index so the counter never wraps inside a phase.
    assign idx_clr  = !idx_en || idx_tc || abort;
    assign wait_end = ((state == S_DRAIN)  && (wait_cnt == WAIT_W'(RD_LAT - 1))) ||
                      ((state == S_SETTLE) && (wait_cnt == WAIT_W'(CALC_LAT - 1)));

    matmul_idx_cnt #(
        .ADDR_W (ADDR_W),
        .TERM   (TERM)
    ) u_idx_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (idx_clr),
        .en    (idx_en),
        .cnt   (idx),
        .tc    (idx_tc)
    );

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start)    state_nxt = S_LOAD;
                S_LOAD:   if (idx_tc)   state_nxt = S_DRAIN;
                S_DRAIN:  if (wait_end) state_nxt = S_SETTLE;
                S_SETTLE: if (wait_end) state_nxt = S_STORE;
                S_STORE:  if (idx_tc)   state_nxt = S_DONE;
                S_DONE:                 state_nxt = S_IDLE;
                default:                state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (wait_end || abort || !((state == S_DRAIN) || (state == S_SETTLE)))
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // Address-to-capture pipe mirrors the ROM read latency; abort flushes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++)
                pipe_idx[i] <= '0;
        end else begin
            pipe_vld[0] <= (state == S_LOAD) && !abort;
            pipe_idx[0] <= ((state == S_LOAD) && !abort) ? idx : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1] && !abort;
                pipe_idx[i] <= abort ? '0 : pipe_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_sticky <= 1'b0;
        else if (accept)
            ovf_sticky <= 1'b0;
        else if ((state == S_STORE) && ovf_in && !abort)
            ovf_sticky <= 1'b1;
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign rom_raddr = (state == S_LOAD)  ? idx : '0;
    assign res_idx   = (state == S_STORE) ? idx : '0;
    assign ram_waddr = res_idx;
    assign ram_wen   = (state == S_STORE);
    assign cap_en    = pipe_vld[RD_LAT-1];
    assign cap_idx   = pipe_idx[RD_LAT-1];

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a behavioural ROM, operand regs, Q8.8 tree and RAM.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       ovf_in;
    logic       busy, done, cap_en, ram_wen, ovf_sticky;
    logic [3:0] rom_raddr, cap_idx, res_idx, ram_waddr;
    logic [19:0] obs_v;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] a_rom [ELEMS];
    logic [N-1:0] b_rom [ELEMS];
    logic [N-1:0] op_a  [ELEMS];
    logic [N-1:0] op_b  [ELEMS];
    logic [N-1:0] ram   [ELEMS];
    logic [N-1:0] a_q, b_q, res_val;

    always #5 clk = ~clk;

    matmul_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .rom_raddr  (rom_raddr),
        .cap_en     (cap_en),
        .cap_idx    (cap_idx),
        .res_idx    (res_idx),
        .ram_wen    (ram_wen),
        .ram_waddr  (ram_waddr),
        .ovf_in     (ovf_in),
        .ovf_sticky (ovf_sticky)
    );

    assign obs_v = {busy, done, cap_en, ram_wen, rom_raddr, cap_idx, ram_waddr, res_idx};

    always @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            for (int i = 0; i < ELEMS; i++) begin
                op_a[i] <= '0;
                op_b[i] <= '0;
                ram[i]  <= '0;
            end
        end else begin
            a_q <= a_rom[rom_raddr];
            b_q <= b_rom[rom_raddr];
            if (cap_en) begin
                op_a[cap_idx] <= a_q;
                op_b[cap_idx] <= b_q;
            end
            if (ram_wen)
                ram[ram_waddr] <= res_val;
        end
    end

    always_comb begin : tree
        longint acc;
        longint p;
        int     row;
        int     col;
        acc    = 0;
        p      = 0;
        ovf_in = 1'b0;
        row    = int'(res_idx) / DIM;
        col    = int'(res_idx) % DIM;
        for (int k = 0; k < DIM; k++) begin
            p = (longint'($signed(op_a[row*DIM+k])) * longint'($signed(op_b[k*DIM+col]))) >>> Q;
            if (p > 32767 || p < -32768)
                ovf_in = 1'b1;
            acc = acc + p;
        end
        if (acc > 32767 || acc < -32768)
            ovf_in = 1'b1;
        res_val = N'(acc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Expected output vector for cycle c of an undisturbed job (cycle 0 = start accept).
    function automatic logic [19:0] expv(input int c);
        logic b, d, ce, we;
        int   ra, ci, wa;
        b  = (c >= 1)  && (c <= 36);
        d  = (c == 36);
        ce = (c >= 2)  && (c <= 17);
        we = (c >= 20) && (c <= 35);
        ra = (c >= 1 && c <= 16) ? c - 1 : 0;
        ci = ce ? c - 2 : 0;
        wa = we ? c - 20 : 0;
        return {b, d, ce, we, 4'(ra), 4'(ci), 4'(wa), 4'(wa)};
    endfunction

    task automatic run_job(input int rp1, input int rp2, input int ncyc,
                           output int dcyc, output int dn, output int wn);
        dcyc = -1;
        dn   = 0;
        wn   = 0;
        start = 1'b1;
        tick();
        for (int c = 1; c <= ncyc; c++) begin
            start = (c == rp1) || (c == rp2);
            if (done) begin
                dn++;
                dcyc = c;
            end
            if (ram_wen)
                wn++;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic load_roms(input int mode);
        for (int i = 0; i < ELEMS; i++) begin
            case (mode)
                0: begin
                    a_rom[i] = (i / DIM == i % DIM) ? 16'h0100 : 16'h0000;
                    b_rom[i] = 16'(i * 256);
                end
                1: begin
                    a_rom[i] = 16'h7F00;
                    b_rom[i] = 16'h7F00;
                end
                default: begin
                    a_rom[i] = (i / DIM == i % DIM) ? 16'h0200 : 16'h0000;
                    b_rom[i] = 16'(i * 256);
                end
            endcase
        end
    endtask

    initial begin
        int dcyc, dn, wn, ram_probe, dn2, wn2;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        load_roms(0);
        #12;
        chk("reset_outs", 32'(obs_v), 32'h0);
        chk("reset_ovf", 32'(ovf_sticky), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // 1: cycle-exact timeline of a full job
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 38; c++) begin
            chk($sformatf("t1_c%0d", c), 32'(obs_v), 32'(expv(c)));
            tick();
        end

        // 2: identity times ramp
        load_roms(0);
        run_job(0, 0, 45, dcyc, dn, wn);
        chk("t2_done_cyc", 32'(dcyc), 32'd36);
        chk("t2_wen_cnt", 32'(wn), 32'd16);
        chk("t2_ovf", 32'(ovf_sticky), 32'h0);
        for (int k = 0; k < ELEMS; k++)
            chk($sformatf("t2_ram%0d", k), 32'(ram[k]), 32'(k * 256));

        // 3: saturating operands set the sticky flag, next start clears it
        load_roms(1);
        run_job(0, 0, 45, dcyc, dn, wn);
        chk("t3_ovf_set", 32'(ovf_sticky), 32'h1);
        load_roms(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_ovf_clr", 32'(ovf_sticky), 32'h0);
        for (int c = 1; c <= 44; c++)
            tick();
        chk("t3_ovf_after", 32'(ovf_sticky), 32'h0);
        chk("t3_ram5", 32'(ram[5]), 32'h0500);

        // 4: restarts while busy are ignored; start right after done is accepted
        run_job(5, 20, 36, dcyc, dn, wn);
        chk("t4_done_cyc", 32'(dcyc), 32'd36);
        chk("t4_done_cnt", 32'(dn), 32'd1);
        chk("t4_idle37", 32'(busy), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_relaunch", 32'(obs_v), 32'(expv(1)));
        for (int c = 2; c <= 40; c++)
            tick();

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_idle", 32'(busy), 32'h0);

        // 5: abort during LOAD
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++)
            tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_outs", 32'({busy, cap_en, ram_wen}), 32'h0);
        dn2 = 0;
        wn2 = 0;
        for (int c = 0; c < 40; c++) begin
            if (done)    dn2++;
            if (ram_wen) wn2++;
            tick();
        end
        chk("t5_no_done", 32'(dn2), 32'h0);
        chk("t5_no_wen", 32'(wn2), 32'h0);
        load_roms(2);
        run_job(0, 0, 45, dcyc, dn, wn);
        chk("t5_done_cyc", 32'(dcyc), 32'd36);
        chk("t5_wen_cnt", 32'(wn), 32'd16);
        ram_probe = int'(ram[15]);
        chk("t5_ram15", 32'(ram_probe), 32'h1E00);
        chk("t5_ram3", 32'(ram[3]), 32'h0600);

        // 6: asynchronous reset mid-STORE
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 24; c++)
            tick();
        chk("t6_in_store", 32'(ram_wen), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_outs", 32'({obs_v, ovf_sticky}), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("t6_idle", 32'(busy), 32'h0);
        run_job(0, 0, 45, dcyc, dn, wn);
        chk("t6_done_cyc", 32'(dcyc), 32'd36);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
